alarm_controller_multi: RTL and testbench

//  Parametrised key-entry / display-mode FSM for the digital alarm clock, successor to the single-alarm controller.

---
 rtl/alarm_controller_multi.sv | 130 +++++++++++++
 tb/tb_alarm_controller_multi.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller_multi.sv
// ============================================================================
// Module      : alarm_controller_multi
// Description : Key-entry / display-mode FSM for a multi-alarm digital clock.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_controller_multi #(
  parameter  int TIMEOUT_SEC = 10,
  parameter  int NUM_ALARMS  = 2,
  parameter  int DIGITS      = 4,
  parameter  int NOKEY       = 10,
  localparam int SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int DCNT_W      = $clog2(DIGITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  one_second,
  input  logic                  time_button,
  input  logic                  alarm_button,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [3:0]            key,
  output logic                  shift,
  output logic                  show_new_time,
  output logic                  show_a,
  output logic [SEL_W-1:0]      alarm_idx,
  output logic [NUM_ALARMS-1:0] load_new_a,
  output logic                  load_new_c,
  output logic                  reset_count,
  output logic [DCNT_W-1:0]     digit_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_SEC + 1);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [TMR_W-1:0]  timer;
  logic              timeout;
  logic              key_hit;
  logic              entry_full;
  logic [SEL_W-1:0]  sel_eff;
  logic              timed_state;

  assign timeout     = (timer == TMR_W'(TIMEOUT_SEC));
  assign key_hit     = (key != 4'(NOKEY));
  assign entry_full  = (digit_cnt == DCNT_W'(DIGITS));
  assign sel_eff     = (int'(alarm_sel) < NUM_ALARMS) ? alarm_sel : '0;
  assign timed_state = (state == KEY_ENTRY) || (state == KEY_WAITED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SHOW_TIME;
      timer     <= '0;
      digit_cnt <= '0;
      alarm_idx <= '0;
    end else begin
      state <= next_state;

      // Inactivity timer restarts on any state change, including each new key.
      if ((state != next_state) || !timed_state)
        timer <= '0;
      else if (one_second && !timeout)
        timer <= timer + TMR_W'(1);

      if ((state == SHOW_TIME) && (next_state == KEY_STORED))
        digit_cnt <= '0;
      else if ((state == KEY_STORED) && !entry_full)
        digit_cnt <= digit_cnt + DCNT_W'(1);

      if ((next_state == SHOW_ALARM) || (next_state == SET_ALARM_TIME))
        alarm_idx <= sel_eff;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)  next_state = SHOW_ALARM;
        else if (key_hit)  next_state = KEY_STORED;
      end
      KEY_STORED:          next_state = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_hit)      next_state = KEY_ENTRY;
        else if (timeout)  next_state = SHOW_TIME;
      end
      KEY_ENTRY: begin
        // Commits only complete entries; a partial entry aborts without loading.
        if (alarm_button)
          next_state = entry_full ? SET_ALARM_TIME : SHOW_TIME;
        else if (time_button)
          next_state = entry_full ? SET_CURRENT_TIME : SHOW_TIME;
        else if (timeout)
          next_state = SHOW_TIME;
        else if (key_hit && !entry_full)
          next_state = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button) next_state = SHOW_TIME;
      end
      SET_ALARM_TIME:      next_state = SHOW_TIME;
      SET_CURRENT_TIME:    next_state = SHOW_TIME;
      default:             next_state = SHOW_TIME;
    endcase
  end

  always_comb begin
    shift         = (state == KEY_STORED);
    show_new_time = (state == KEY_STORED) || timed_state;
    show_a        = (state == SHOW_ALARM);
    load_new_c    = (state == SET_CURRENT_TIME);
    reset_count   = (state == SET_CURRENT_TIME);
    load_new_a    = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      load_new_a[i] = (state == SET_ALARM_TIME) && (int'(alarm_idx) == i);
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller_multi.sv
// ============================================================================
// Module      : tb_alarm_controller_multi
// Description : Scoreboard bench for alarm_controller_multi (default parameters).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_controller_multi;

  localparam logic [3:0] NK = 4'd10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic       time_button = 1'b0;
  logic       alarm_button = 1'b0;
  logic [0:0] alarm_sel = 1'b0;
  logic [3:0] key = NK;
  logic       shift, show_new_time, show_a, load_new_c, reset_count;
  logic [0:0] alarm_idx;
  logic [1:0] load_new_a;
  logic [2:0] digit_cnt;

  int tests = 0;
  int fails = 0;

  // Event record: {shift, load_new_a, load_new_c, reset_count, digit_cnt}
  logic [7:0] exp_q[$];

  alarm_controller_multi dut (
    .clock(clk), .reset(reset), .one_second(one_second),
    .time_button(time_button), .alarm_button(alarm_button),
    .alarm_sel(alarm_sel), .key(key), .shift(shift),
    .show_new_time(show_new_time), .show_a(show_a), .alarm_idx(alarm_idx),
    .load_new_a(load_new_a), .load_new_c(load_new_c),
    .reset_count(reset_count), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [7:0] ev;
    logic [7:0] ex;
    if (!reset && (shift || (|load_new_a) || load_new_c || reset_count)) begin
      ev = {shift, load_new_a, load_new_c, reset_count, digit_cnt};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL event: unexpected output event %b, none expected", ev);
      end else begin
        ex = exp_q.pop_front();
        if (ev !== ex) begin
          fails++;
          $display("FAIL event: got %b expected %b", ev, ex);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_shift(input logic [2:0] cnt);
    exp_q.push_back({1'b1, 2'b00, 1'b0, 1'b0, cnt});
  endtask

  task automatic press(input logic [3:0] k);
    key = k;
    step(3);
    key = NK;
    step(2);
  endtask

  task automatic pulse_sec(input int n);
    for (int i = 0; i < n; i++) begin
      one_second = 1'b1;
      step(1);
      one_second = 1'b0;
      step(1);
    end
  endtask

  task automatic four_keys;
    for (int d = 0; d < 4; d++) begin
      push_shift(3'(d));
      press(4'(d + 1));
    end
  endtask

  initial begin
    step(3);
    chk("reset_outputs", {shift, show_new_time, show_a, load_new_a, load_new_c, reset_count}, 0);
    chk("reset_digit_cnt", digit_cnt, 0);
    chk("reset_alarm_idx", alarm_idx, 0);
    reset = 1'b0;
    step(1);

    // Reset in the middle of an entry
    push_shift(3'd0);
    press(4'd1);
    push_shift(3'd1);
    key = 4'd2;
    step(3);
    chk("mid_entry_show_new", show_new_time, 1);
    chk("mid_entry_cnt", digit_cnt, 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    key = NK;
    chk("mid_reset_outputs", {shift, show_new_time, show_a, load_new_a, load_new_c, reset_count}, 0);
    chk("mid_reset_cnt", digit_cnt, 0);
    step(1);

    // Four digits, fifth ignored, alarm commit to channel 1
    four_keys();
    press(4'd5);
    chk("fifth_key_cnt", digit_cnt, 4);
    chk("fifth_key_in_entry", show_new_time, 1);
    alarm_sel = 1'b1;
    alarm_button = 1'b1;
    exp_q.push_back({1'b0, 2'b10, 1'b0, 1'b0, 3'd4});
    step(1);
    alarm_button = 1'b0;
    alarm_sel = 1'b0;
    step(1);
    chk("after_alarm_commit", {show_new_time, show_a}, 0);

    // Partial entry + time_button aborts
    push_shift(3'd0);
    press(4'd1);
    push_shift(3'd1);
    press(4'd2);
    time_button = 1'b1;
    step(1);
    time_button = 1'b0;
    chk("partial_abort_show", show_new_time, 0);
    chk("partial_abort_cnt_hold", digit_cnt, 2);
    step(1);

    // Full entry + time_button commits current time
    four_keys();
    time_button = 1'b1;
    exp_q.push_back({1'b0, 2'b00, 1'b1, 1'b1, 3'd4});
    step(1);
    time_button = 1'b0;
    step(1);
    chk("after_time_commit", show_new_time, 0);

    // Both buttons together: alarm commit to channel 0 wins
    four_keys();
    alarm_button = 1'b1;
    time_button = 1'b1;
    exp_q.push_back({1'b0, 2'b01, 1'b0, 1'b0, 3'd4});
    step(1);
    alarm_button = 1'b0;
    time_button = 1'b0;
    step(1);

    // Idle timeout in KEY_ENTRY
    push_shift(3'd0);
    press(4'd7);
    pulse_sec(9);
    chk("entry_9_pulses_stay", show_new_time, 1);
    pulse_sec(1);
    chk("entry_10_pulses_abort", show_new_time, 0);

    // Key held through the timeout in KEY_WAITED
    push_shift(3'd0);
    key = 4'd3;
    step(3);
    pulse_sec(9);
    chk("waited_9_pulses_stay", show_new_time, 1);
    one_second = 1'b1;
    step(1);
    one_second = 1'b0;
    step(1);
    key = NK;
    chk("waited_10_pulses_abort", show_new_time, 0);
    step(1);

    // Alarm display tracks alarm_sel while held
    alarm_button = 1'b1;
    alarm_sel = 1'b0;
    step(1);
    chk("show_alarm_on", show_a, 1);
    chk("show_alarm_idx0", alarm_idx, 0);
    alarm_sel = 1'b1;
    step(1);
    chk("show_alarm_idx1", alarm_idx, 1);
    alarm_button = 1'b0;
    step(1);
    chk("show_alarm_release", {show_a, show_new_time}, 0);

    step(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
